// File: rtl/mux_pkg.sv
// Shared constants for the datapath word multiplexers.
// Select encoding plus default width and reset value.
// No logic; imported by the mux core and the registered top.
package mux_pkg;

   localparam int              MUX_WIDTH     = 16;
   localparam logic [15:0]     MUX_RESET_VAL = 16'h0000;
   localparam logic            SEL_I0        = 1'b0;
   localparam logic            SEL_I1        = 1'b1;

endpackage

// File: rtl/mux2to1_core.sv
// Combinational WIDTH-bit two-input word selector.
// Latency: zero; output follows I0/I1/S in the same delta.
// Backpressure: none, pure combinational path.
module mux2to1_core
   import mux_pkg::*;
#(
   parameter int WIDTH = MUX_WIDTH
) (
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             S,
   output logic [WIDTH-1:0] Y
);

   // An unknown select yields all-X rather than quietly favouring one input.
   always_comb begin
      Y = '0;
      case (S)
         SEL_I0:  Y = I0;
         SEL_I1:  Y = I1;
         default: Y = 'x;
      endcase
   end

endmodule

// File: rtl/mux2to1_16bit.sv
// 2:1 word mux with combinational and registered outputs; MUX2TO1_PARITY_EN adds Parity_q.
// Latency: Output zero cycles, Output_q/Sel_q one cycle when En=1.
// Backpressure: none; En=0 holds the registered copy.
module mux2to1_16bit
   import mux_pkg::*;
#(
   parameter int               WIDTH     = MUX_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = MUX_RESET_VAL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             S,
   input  logic             En,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] Output_q,
   output logic             Sel_q
`ifdef MUX2TO1_PARITY_EN
   ,output logic            Parity_q
`endif
);

   mux2to1_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .I0 (I0),
      .I1 (I1),
      .S  (S),
      .Y  (Output)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Output_q <= RESET_VAL;
         Sel_q    <= SEL_I0;
      end else if (En) begin
         Output_q <= Output;
         Sel_q    <= S;
      end
   end

`ifdef MUX2TO1_PARITY_EN
   // Parity of the word actually loaded, so it always matches Output_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Parity_q <= ^RESET_VAL;
      end else if (En) begin
         Parity_q <= ^Output;
      end
   end
`endif

endmodule

// File: tb/tb_mux2to1_16bit.sv
// Directed bench for mux2to1_16bit: reset, combinational select, load, hold, async reset.
// Parity checks are compiled in when MUX2TO1_PARITY_EN is defined.
module tb_mux2to1_16bit;

   logic        clk;
   logic        rst_n;
   logic [15:0] I0;
   logic [15:0] I1;
   logic        S;
   logic        En;
   logic [15:0] Output;
   logic [15:0] Output_q;
   logic        Sel_q;
`ifdef MUX2TO1_PARITY_EN
   logic        Parity_q;
`endif

   int checks = 0;
   int fails  = 0;

   mux2to1_16bit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .I0       (I0),
      .I1       (I1),
      .S        (S),
      .En       (En),
      .Output   (Output),
      .Output_q (Output_q),
      .Sel_q    (Sel_q)
`ifdef MUX2TO1_PARITY_EN
      ,.Parity_q (Parity_q)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with inputs already applied
      rst_n = 1'b0;
      I0    = 16'h1234;
      I1    = 16'h5678;
      S     = 1'b0;
      En    = 1'b0;
      #1;
      check("rst_output", Output, 16'h1234);
      check("rst_output_q", Output_q, 16'h0000);
      check("rst_sel_q", {15'd0, Sel_q}, 16'h0000);
`ifdef MUX2TO1_PARITY_EN
      check("rst_parity_q", {15'd0, Parity_q}, 16'h0000);
`endif

      // Clock edges with En=1, S=1 must not load while reset is held
      En = 1'b1;
      S  = 1'b1;
      edge_sample();
      check("rst_hold_output_q", Output_q, 16'h0000);
      check("rst_hold_sel_q", {15'd0, Sel_q}, 16'h0000);
      check("rst_comb_s1", Output, 16'h5678);

      // Release reset away from any clock edge
      En = 1'b0;
      S  = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      check("comb_s0", Output, 16'h1234);
      #10;
      S = 1'b1;
      #1;
      check("comb_s1", Output, 16'h5678);
      check("comb_no_load", Output_q, 16'h0000);

      // Registered path
      En = 1'b1;
      edge_sample();
      check("load1_output_q", Output_q, 16'h5678);
      check("load1_sel_q", {15'd0, Sel_q}, 16'h0001);
      S = 1'b0;
      edge_sample();
      check("load2_output_q", Output_q, 16'h1234);
      check("load2_sel_q", {15'd0, Sel_q}, 16'h0000);

      // Hold: inputs move, registers stay
      En = 1'b0;
      I1 = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         S = ~S;
         #1;
         check("hold_comb", Output, (i % 2 == 0) ? 16'hFFFF : 16'h1234);
         edge_sample();
         check("hold_output_q", Output_q, 16'h1234);
         check("hold_sel_q", {15'd0, Sel_q}, 16'h0000);
      end

      // Load 5678 then pulse reset between edges
      I1 = 16'h5678;
      S  = 1'b1;
      En = 1'b1;
      edge_sample();
      check("pre_arst_output_q", Output_q, 16'h5678);
      check("pre_arst_sel_q", {15'd0, Sel_q}, 16'h0001);
      En = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_output_q", Output_q, 16'h0000);
      check("arst_sel_q", {15'd0, Sel_q}, 16'h0000);
      check("arst_output", Output, 16'h5678);
      #1;
      rst_n = 1'b1;
      edge_sample();
      check("post_arst_hold", Output_q, 16'h0000);

      // Further patterns, all bits pass straight through
      I0 = 16'hA5A5;
      I1 = 16'h5A5A;
      S  = 1'b0;
      En = 1'b1;
      #1;
      check("pat_comb_i0", Output, 16'hA5A5);
      edge_sample();
      check("pat_q_i0", Output_q, 16'hA5A5);
      S = 1'b1;
      edge_sample();
      check("pat_q_i1", Output_q, 16'h5A5A);
      I0 = 16'h0000;
      I1 = 16'hFFFF;
      edge_sample();
      check("pat_q_ones", Output_q, 16'hFFFF);
      S = 1'b0;
      edge_sample();
      check("pat_q_zeros", Output_q, 16'h0000);

`ifdef MUX2TO1_PARITY_EN
      I0 = 16'h0001;
      S  = 1'b0;
      edge_sample();
      check("parity_odd", {15'd0, Parity_q}, 16'h0001);
      I0 = 16'h0003;
      edge_sample();
      check("parity_even", {15'd0, Parity_q}, 16'h0000);
      I1 = 16'h8000;
      S  = 1'b1;
      En = 1'b0;
      edge_sample();
      check("parity_hold", {15'd0, Parity_q}, 16'h0000);
`endif

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/mux2to1_16bit.md
Name: mux2to1_16bit

Overview:
- 16-bit two-input word multiplexer for the multi-cycle 16-bit RISC datapath, e.g. PC source, ALU operand and register write-back selection.
- Provides a zero-latency combinational output, Output.
- Also provides a registered copy, Output_q, for paths that need a flopped select result.
- Single clock domain; asynchronous active-low reset affects only the registered path.

Parameters:
- WIDTH, 16, data width of I0, I1, Output and Output_q. Only 16 is verified.
- RESET_VAL, 16'h0000, value loaded into Output_q on reset.

Ports:
- clk  input  1  system clock; registered state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert and synchronous-safe deassert, active-low.
- I0  input  WIDTH  data input selected when S=0.
- I1  input  WIDTH  data input selected when S=1.
- S  input  1  select.
- En  input  1  load enable for Output_q.
- Output  output  WIDTH  combinational result.
- Output_q  output  WIDTH  registered result.
- Sel_q  output  1  registered copy of S, captured with Output_q.

Behaviour:
- Output = S ? I1 : I0. Purely combinational, zero latency, no dependence on clk or rst_n. It must change in the same delta as any change on I0, I1 or S.
- If S is X or Z, Output is driven all-X. Never silently pick an input.
- While rst_n=0, regardless of clk: Output_q = RESET_VAL and Sel_q = 0.
- Asserting rst_n mid-operation clears both registers immediately. Output is unaffected by reset.
- On a rising clk edge with rst_n=1 and En=1: Output_q <= (S ? I1 : I0) and Sel_q <= S, sampled at the edge. This gives one cycle of latency relative to Output.
- On a rising clk edge with En=0: Output_q and Sel_q hold their values.
- If rst_n deasserts coincident with a clk edge, that edge performs no load. The first load happens on the next edge.
- No arithmetic, no width conversion, no state machine. All bits pass straight through; no wrap or saturation applies.

Optional Feature:
- Macro MUX2TO1_PARITY_EN.
- When defined, add output Parity_q (1 bit).
  - Parity_q is the registered even-parity bit (XOR reduction) of the selected word.
  - It loads under the same En/clk rule as Output_q.
  - It resets to the parity of RESET_VAL (0 for the default).
- When undefined, the Parity_q port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package mux_pkg: WIDTH default constant (16), RESET_VAL constant, and the select encoding constants SEL_I0=1'b0 and SEL_I1=1'b1.
- One natural sub-module, mux2to1_core: the combinational WIDTH-bit selector. The top instantiates it once and adds the register stage and the optional parity logic.

Test Plan:
- Reset: rst_n=0 with I0=16'h1234, I1=16'h5678, S=0 -> Output=16'h1234 immediately; Output_q=16'h0000 and Sel_q=0 throughout reset.
- Combinational select: rst_n=1, S=0 -> Output=16'h1234. After 10 ns set S=1 -> Output=16'h5678 with no clock edge needed.
- Registered path: En=1, S=1, one rising edge -> Output_q=16'h5678, Sel_q=1. Set S=0, next edge -> Output_q=16'h1234, Sel_q=0.
- Hold: En=0, then toggle S and change I1 to 16'hFFFF over 3 edges -> Output tracks the inputs; Output_q and Sel_q stay unchanged.
- Async reset mid-run: Output_q=16'h5678, pulse rst_n low between edges -> Output_q=16'h0000 immediately, before the next edge.
- With MUX2TO1_PARITY_EN defined: select 16'h0001 and clock -> Parity_q=1. Select 16'h0003 and clock -> Parity_q=0.
